// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
// -----------------
// Hazard and forwarding controller for the in-order pipelined datapath.
// A shift-register scoreboard records {valid, we, addr, isLoad} for every
// instruction past decode: entry 0 = EX, entry 1 = MEM, entry 2 = WB (defaults).
// Decode sources are matched against it to produce the load-use stall, the
// registered EX forwarding selects and the taken-branch flushes.
//
// Ports
//   clk_i, rst_i           clock, synchronous active-high reset
//   issueValid_i           decode holds a valid instruction
//   rsAddr_i, rtAddr_i     decode source registers
//   useRs_i, useRt_i       decode instruction reads rs / rt
//   regWrite_i             decode instruction writes a register
//   memToRead_i            decode instruction is a load
//   writeAddr_i            decode destination register
//   branchTaken_i          branch at entry BRANCH_STAGE resolves taken
//   stall_o                hold PC and F/D, bubble into D/E (combinational)
//   flushFD_o, flushDE_o   clear F/D and D/E buffers (combinational)
//   fwdA_o, fwdB_o         registered EX operand selects: 0 = register file,
//                          k = value held in scoreboard entry k
//   stallCount_o           saturating count of stall cycles
//   flushCount_o           saturating count of taken-branch cycles
//
// Handshake: there is no backpressure on decode. An instruction presented with
// issueValid_i = 1 is accepted on the clock edge of a cycle where stall_o = 0
// and branchTaken_i = 0; otherwise decode must hold (stall) or is discarded
// (flush) and a bubble enters entry 0.

module hazard_scoreboard #(
    parameter int REG_ADDR_W   = 5,
    parameter int STAGES       = 3,
    parameter int LOAD_STAGE   = 1,
    parameter int BRANCH_STAGE = 1,
    parameter int CNT_W        = 16,
    localparam int FWD_W       = ($clog2(STAGES) > 1) ? $clog2(STAGES) : 1
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  issueValid_i,
    input  logic [REG_ADDR_W-1:0] rsAddr_i,
    input  logic [REG_ADDR_W-1:0] rtAddr_i,
    input  logic                  useRs_i,
    input  logic                  useRt_i,
    input  logic                  regWrite_i,
    input  logic                  memToRead_i,
    input  logic [REG_ADDR_W-1:0] writeAddr_i,
    input  logic                  branchTaken_i,
    output logic                  stall_o,
    output logic                  flushFD_o,
    output logic                  flushDE_o,
    output logic [FWD_W-1:0]      fwdA_o,
    output logic [FWD_W-1:0]      fwdB_o,
    output logic [CNT_W-1:0]      stallCount_o,
    output logic [CNT_W-1:0]      flushCount_o
);

    // Elaboration-time parameter sanity.
    generate
        if (STAGES < 2) begin : gBadStages
            $error("hazard_scoreboard: STAGES must be at least 2");
        end
        if (LOAD_STAGE >= STAGES) begin : gBadLoad
            $error("hazard_scoreboard: LOAD_STAGE must be below STAGES");
        end
        if (BRANCH_STAGE >= STAGES) begin : gBadBranch
            $error("hazard_scoreboard: BRANCH_STAGE must be below STAGES");
        end
    endgenerate

    // Scoreboard storage, index 0 is the youngest instruction.
    logic [STAGES-1:0]     entValid;
    logic [STAGES-1:0]     entWe;
    logic [STAGES-1:0]     entLoad;
    logic [REG_ADDR_W-1:0] entAddr [STAGES];

    // Youngest-match search per source operand.
    logic             rsHit;
    logic             rtHit;
    logic [FWD_W-1:0] rsIdx;
    logic [FWD_W-1:0] rtIdx;

    always_comb begin
        rsHit = 1'b0;
        rtHit = 1'b0;
        rsIdx = '0;
        rtIdx = '0;
        // Walk from oldest to youngest so the lowest index overwrites last.
        for (int k = STAGES - 1; k >= 0; k--) begin
            // Register zero is hard-wired, so a write to it is never a producer.
            if (entValid[k] && entWe[k] && (entAddr[k] != '0)) begin
                if (useRs_i && (entAddr[k] == rsAddr_i)) begin
                    rsHit = 1'b1;
                    rsIdx = FWD_W'(k);
                end
                if (useRt_i && (entAddr[k] == rtAddr_i)) begin
                    rtHit = 1'b1;
                    rtIdx = FWD_W'(k);
                end
            end
        end
    end

    // A load's data does not exist yet while it sits at or before LOAD_STAGE
    // one edge from now, so the consumer has to wait in decode.
    logic rsLoadHaz;
    logic rtLoadHaz;
    logic stallInt;
    logic insert;

    always_comb begin
        rsLoadHaz = rsHit && entLoad[rsIdx] && ((int'(rsIdx) + 1) <= LOAD_STAGE);
        rtLoadHaz = rtHit && entLoad[rtIdx] && ((int'(rtIdx) + 1) <= LOAD_STAGE);
        // Flush wins over stall: the stalled instruction is discarded anyway.
        stallInt  = issueValid_i && (rsLoadHaz || rtLoadHaz) && !branchTaken_i;
        insert    = issueValid_i && !stallInt && !branchTaken_i;
    end

    assign stall_o   = stallInt && !rst_i;
    assign flushFD_o = branchTaken_i && !rst_i;
    assign flushDE_o = branchTaken_i && !rst_i;

    // Forward select for the next cycle: the producer found at entry k will
    // be at entry k+1 when the consumer reaches EX. A producer that retires
    // on this edge has already written the register file.
    logic [FWD_W-1:0] fwdANext;
    logic [FWD_W-1:0] fwdBNext;

    always_comb begin
        fwdANext = '0;
        fwdBNext = '0;
        if (insert) begin
            if (rsHit && ((int'(rsIdx) + 1) <= (STAGES - 1))) begin
                fwdANext = rsIdx + FWD_W'(1);
            end
            if (rtHit && ((int'(rtIdx) + 1) <= (STAGES - 1))) begin
                fwdBNext = rtIdx + FWD_W'(1);
            end
        end
    end

    // Scoreboard shift, forward-select registers and event counters.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            entValid     <= '0;
            entWe        <= '0;
            entLoad      <= '0;
            for (int k = 0; k < STAGES; k++) begin
                entAddr[k] <= '0;
            end
            fwdA_o       <= '0;
            fwdB_o       <= '0;
            stallCount_o <= '0;
            flushCount_o <= '0;
        end else begin
            for (int k = STAGES - 1; k >= 1; k--) begin
                // Instructions younger than the resolving branch are on the
                // wrong path and are killed as they move down.
                entValid[k] <= entValid[k-1] && !(branchTaken_i && ((k - 1) < BRANCH_STAGE));
                entWe[k]    <= entWe[k-1];
                entLoad[k]  <= entLoad[k-1];
                entAddr[k]  <= entAddr[k-1];
            end
            entValid[0] <= insert;
            entWe[0]    <= insert && regWrite_i;
            entLoad[0]  <= insert && memToRead_i;
            entAddr[0]  <= insert ? writeAddr_i : '0;

            fwdA_o <= fwdANext;
            fwdB_o <= fwdBNext;

            if (stallInt && (stallCount_o != '1)) begin
                stallCount_o <= stallCount_o + CNT_W'(1);
            end
            if (branchTaken_i && (flushCount_o != '1)) begin
                flushCount_o <= flushCount_o + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: a default-parameter instance plus a CNT_W = 4
// instance sharing the same stimulus for counter saturation.
module tb_hazard_scoreboard;

    localparam int FWD_W = 2;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       issueValid;
    logic [4:0] rsAddr;
    logic [4:0] rtAddr;
    logic       useRs;
    logic       useRt;
    logic       regWrite;
    logic       memToRead;
    logic [4:0] writeAddr;
    logic       branchTaken;

    logic             stall, flushFD, flushDE;
    logic [FWD_W-1:0] fwdA, fwdB;
    logic [15:0]      stallCount, flushCount;

    logic             satStall, satFlushFD, satFlushDE;
    logic [FWD_W-1:0] satFwdA, satFwdB;
    logic [3:0]       satStallCount, satFlushCount;

    hazard_scoreboard dut (
        .clk_i(clk), .rst_i(rst), .issueValid_i(issueValid),
        .rsAddr_i(rsAddr), .rtAddr_i(rtAddr), .useRs_i(useRs), .useRt_i(useRt),
        .regWrite_i(regWrite), .memToRead_i(memToRead), .writeAddr_i(writeAddr),
        .branchTaken_i(branchTaken), .stall_o(stall), .flushFD_o(flushFD),
        .flushDE_o(flushDE), .fwdA_o(fwdA), .fwdB_o(fwdB),
        .stallCount_o(stallCount), .flushCount_o(flushCount)
    );

    hazard_scoreboard #(.CNT_W(4)) dutSat (
        .clk_i(clk), .rst_i(rst), .issueValid_i(issueValid),
        .rsAddr_i(rsAddr), .rtAddr_i(rtAddr), .useRs_i(useRs), .useRt_i(useRt),
        .regWrite_i(regWrite), .memToRead_i(memToRead), .writeAddr_i(writeAddr),
        .branchTaken_i(branchTaken), .stall_o(satStall), .flushFD_o(satFlushFD),
        .flushDE_o(satFlushDE), .fwdA_o(satFwdA), .fwdB_o(satFwdB),
        .stallCount_o(satStallCount), .flushCount_o(satFlushCount)
    );

    // ---------------- scoreboard ----------------
    logic [2*FWD_W-1:0] expQ[$];
    int nChecks     = 0;
    int nErrors     = 0;
    int expStallCnt = 0;
    int expFlushCnt = 0;

    task automatic checkVal(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act !== exp) begin
            nErrors++;
            $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
        end
    endtask

    function automatic int sat15(input int v);
        return (v > 15) ? 15 : v;
    endfunction

    // ---------------- driver tasks ----------------
    // One decode cycle: drive, check combinational outputs, queue the
    // expected forward selects, clock, then pop and compare.
    task automatic step(input int v, input int rs, input int rt, input int uRs, input int uRt,
                        input int we, input int ld, input int wa, input int br,
                        input int eStall, input int eA, input int eB);
        logic [2*FWD_W-1:0] e;
        issueValid  = 1'(v);
        rsAddr      = 5'(rs);
        rtAddr      = 5'(rt);
        useRs       = 1'(uRs);
        useRt       = 1'(uRt);
        regWrite    = 1'(we);
        memToRead   = 1'(ld);
        writeAddr   = 5'(wa);
        branchTaken = 1'(br);
        #1;
        checkVal("stall",      32'(stall),      32'(eStall));
        checkVal("flushFD",    32'(flushFD),    32'(br));
        checkVal("flushDE",    32'(flushDE),    32'(br));
        checkVal("satStall",   32'(satStall),   32'(eStall));
        checkVal("satFlushFD", 32'(satFlushFD), 32'(br));
        checkVal("satFlushDE", 32'(satFlushDE), 32'(br));
        expQ.push_back({FWD_W'(eA), FWD_W'(eB)});
        if (eStall != 0) expStallCnt++;
        if (br != 0) expFlushCnt++;
        @(posedge clk);
        #1;
        if (expQ.size() == 0) begin
            checkVal("expQEmpty", 32'(1), 32'(0));
        end else begin
            e = expQ.pop_front();
            checkVal("fwdA",    32'(fwdA),    32'(e[2*FWD_W-1:FWD_W]));
            checkVal("fwdB",    32'(fwdB),    32'(e[FWD_W-1:0]));
            checkVal("satFwdA", 32'(satFwdA), 32'(e[2*FWD_W-1:FWD_W]));
            checkVal("satFwdB", 32'(satFwdB), 32'(e[FWD_W-1:0]));
        end
        checkVal("stallCount",    32'(stallCount),    expStallCnt);
        checkVal("flushCount",    32'(flushCount),    expFlushCnt);
        checkVal("satStallCount", 32'(satStallCount), sat15(expStallCnt));
        checkVal("satFlushCount", 32'(satFlushCount), sat15(expFlushCnt));
    endtask

    task automatic nop();
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // Reset with a would-be flush and a decode request present: combinational
    // outputs must be masked and all state cleared after one edge.
    task automatic doReset();
        rst         = 1'b1;
        issueValid  = 1'b1;
        rsAddr      = 5'd22;
        useRs       = 1'b1;
        branchTaken = 1'b1;
        #1;
        checkVal("rstStall",   32'(stall),   32'(0));
        checkVal("rstFlushFD", 32'(flushFD), 32'(0));
        checkVal("rstFlushDE", 32'(flushDE), 32'(0));
        @(posedge clk);
        #1;
        rst         = 1'b0;
        branchTaken = 1'b0;
        issueValid  = 1'b0;
        expQ.delete();
        expStallCnt = 0;
        expFlushCnt = 0;
        checkVal("rstFwdA",       32'(fwdA),          32'(0));
        checkVal("rstFwdB",       32'(fwdB),          32'(0));
        checkVal("rstStallCount", 32'(stallCount),    32'(0));
        checkVal("rstFlushCount", 32'(flushCount),    32'(0));
        checkVal("rstSatStall",   32'(satStallCount), 32'(0));
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; issueValid = 1'b0; rsAddr = '0; rtAddr = '0; useRs = 1'b0; useRt = 1'b0;
        regWrite = 1'b0; memToRead = 1'b0; writeAddr = '0; branchTaken = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        doReset();

        // Forward from EX: add r8, then sub reads r8 on rs.
        step(1, 1, 2, 1, 1, 1, 0, 8,  0, 0, 0, 0);
        step(1, 8, 3, 1, 1, 1, 0, 10, 0, 0, 1, 0);
        nop();

        // Load-use: lw r9, add reads r9 on rt -> one stall, then fwdB = 2.
        step(1, 1, 0, 1, 0, 1, 1, 9,  0, 0, 0, 0);
        step(1, 4, 9, 1, 1, 1, 0, 11, 0, 1, 0, 0);
        step(1, 4, 9, 1, 1, 1, 0, 11, 0, 0, 0, 2);
        nop();

        // Register zero never matches; unused sources never match.
        step(1, 1,  0,  1, 0, 1, 1, 0,  0, 0, 0, 0);
        step(1, 0,  0,  1, 1, 1, 1, 12, 0, 0, 0, 0);
        step(1, 12, 12, 0, 0, 0, 0, 0,  0, 0, 0, 0);

        // Youngest match wins; a retiring producer is not forwarded.
        step(1, 2, 3, 1, 1, 1, 0, 5, 0, 0, 0, 0);
        step(1, 6, 7, 1, 1, 1, 0, 5, 0, 0, 0, 0);
        step(1, 5, 5, 1, 1, 0, 0, 0, 0, 0, 1, 1);
        nop();
        step(1, 5, 5, 1, 1, 0, 0, 0, 0, 0, 0, 0);

        // Flush beats stall; the flushed load and the discarded decode
        // instruction must both be gone afterwards.
        step(1, 1,  0, 1, 0, 1, 1, 9,  0, 0, 0, 0);
        step(1, 0,  9, 0, 1, 1, 0, 13, 1, 0, 0, 0);
        step(1, 13, 9, 1, 1, 0, 0, 0,  0, 0, 0, 0);

        // Fill the scoreboard, then reset mid-operation.
        step(1, 30, 31, 1, 1, 1, 0, 20, 0, 0, 0, 0);
        step(1, 30, 31, 1, 1, 1, 0, 21, 0, 0, 0, 0);
        step(1, 30, 31, 1, 1, 1, 1, 22, 0, 0, 0, 0);
        doReset();
        step(1, 22, 21, 1, 1, 0, 0, 0, 0, 0, 0, 0);

        // Self-dependent load held in decode: stalls every other cycle,
        // 21 stalls in total, saturating the 4-bit counter at 15.
        for (int j = 0; j < 42; j++) begin
            step(1, 9, 0, 1, 0, 1, 1, 9, 0, j % 2, ((j >= 2) && (j % 2 == 0)) ? 2 : 0, 0);
        end

        // ---------------- report ----------------
        $display("== %0d vectors applied, %0d miscompares ==", nChecks, nErrors);
        $finish;
    end

endmodule
